irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Peripheral-side interrupt source for the 6502 core. Drives the CPU's active-low irq_n and nmi_n request lines.
- Edge-detects up to NUM_SRC peripheral interrupt inputs into a pending register, masks them with an enable register, and ORs the result into a level-sensitive irq_n.
- Turns NMI requests into guaranteed-width low pulses on nmi_n, with guaranteed high gaps between pulses, so the CPU's falling-edge detector sees every NMI.
- Firmware reaches it through a 4-register memory-mapped window on the 6502 bus.

Parameters:
- NUM_SRC, 8: number of maskable interrupt sources, 1..8.
- NMI_PULSE_CYCLES, 4: nmi_n low time in clk cycles, >=2.
- NMI_GAP_CYCLES, 2: minimum nmi_n high time between back-to-back pulses, >=1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- src_in  input  NUM_SRC  peripheral interrupt lines; a rising edge sets the matching pending bit.
- nmi_src  input  1  NMI request; a rising edge requests one pulse.
- cs  input  1  register window select.
- we  input  1  1 = write, 0 = read (valid while cs=1).
- addr  input  2  register index.
- data_in  input  8  write data.
- data_out  output  8  read data, registered.
- irq_n  output  1  active-low IRQ to the CPU, registered.
- nmi_n  output  1  active-low NMI to the CPU, registered.

Behaviour:
- Reset values: pending=0, enable=0, data_out=0, irq_n=1, nmi_n=1, NMI FSM in IDLE, nmi_req=0. Edge-detect history registers reset to 0, so a source already high at reset release does not fire.
- Source edges: rise[i] = src_in[i] & ~src_prev[i]. pending[i] is set on the clock after the rising edge is sampled.
- irq_n = ~|(pending & enable), registered. irq_n falls 2 cycles after the src_in rising edge.
- Registers:
  - 0 STATUS. Read returns pending. Write is write-1-to-clear.
  - 1 ENABLE. Read/write.
  - 2 FORCE. Write sets pending bits (OR). Reads return 0.
  - 3 VECTOR. Read returns the index of the lowest-numbered set bit of (pending & enable) in bits [2:0], with bit7=0. If none is set, returns 0x80. Writing bit0=1 requests a software NMI.
- Bits at or above NUM_SRC read 0 and ignore writes.
- Reads: data_out updates on the clock edge where cs=1 and we=0, and holds otherwise. Read latency is 1 cycle. Reads have no side effects.
- Same cycle, same bit, STATUS W1C vs hardware edge or FORCE: set wins and the bit stays 1.
- Clearing all enabled pending bits, or clearing their enables, deasserts irq_n on the next clock.
- NMI request latch: nmi_req is set by a nmi_src rising edge or a VECTOR bit0 write.
- NMI FSM:
  - IDLE: if nmi_req, clear nmi_req, drive nmi_n=0, load the counter, go to ASSERT.
  - ASSERT: nmi_n held 0 for NMI_PULSE_CYCLES cycles, then nmi_n=1 and go to GAP.
  - GAP: nmi_n held 1 for NMI_GAP_CYCLES cycles, then go to IDLE.
- Requests arriving during ASSERT or GAP set nmi_req. Multiple such requests collapse into one further pulse.
- A request in the same cycle as nmi_req clears in IDLE is kept and produces a later pulse.
- Reset asserted mid-pulse: nmi_n returns to 1 immediately (asynchronous reset) and all state clears.

Optional Feature:
- Macro: IRQ_CTRL_INPUT_SYNC_EN.
- Defined: src_in and nmi_src each pass through a 2-flop synchronizer (reset to 0) before edge detection. This adds 2 cycles to every input-to-output latency, so src_in edge to irq_n low is 4 cycles.
- Undefined: inputs are used directly and assumed synchronous to clk. Register-path behaviour is identical either way.

Test Plan:
- Reset release with src_in=0xFF held -> pending=0x00, irq_n=1. Write ENABLE=0x01, pulse src_in[0] low then high -> irq_n=0 exactly 2 cycles after the rise.
- pending=0x24, ENABLE=0x20 -> VECTOR reads 0x05. Write STATUS=0x20 -> irq_n=1 next cycle, VECTOR reads 0x80.
- Write STATUS=0x01 in the same cycle as a src_in[0] rising edge -> pending[0] stays 1, irq_n stays 0.
- With ENABLE=0x00, write FORCE=0x03 -> STATUS reads 0x03, irq_n=1. Then write ENABLE=0x02 -> irq_n=0.
- Two nmi_src rising edges 1 cycle apart, defaults -> nmi_n low 4 cycles, high exactly 2 cycles, low 4 cycles, then stays high. Three edges during one pulse -> exactly one extra pulse.
- Write VECTOR=0x01, then assert reset on the 2nd cycle of the low pulse -> nmi_n=1 immediately, and no pulse after reset release.

Source files
------------

// File: rtl/irq_controller.sv
// 6502 interrupt controller: edge-detected maskable IRQ sources, NMI pulse shaper, 4-register bus window. Optional input synchronizers: IRQ_CTRL_INPUT_SYNC_EN.
// Latency: src_in rise to irq_n low 2 cycles (4 with sync), register reads 1 cycle; no backpressure, every bus access completes in one cycle.
module irq_controller #(
  parameter int NUM_SRC          = 8,
  parameter int NMI_PULSE_CYCLES = 4,
  parameter int NMI_GAP_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic               nmi_src,
  input  logic               cs,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [7:0]         data_in,
  output logic [7:0]         data_out,
  output logic               irq_n,
  output logic               nmi_n
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam int CNT_MAX = (NMI_PULSE_CYCLES > NMI_GAP_CYCLES) ? NMI_PULSE_CYCLES : NMI_GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  logic [NUM_SRC-1:0] src_s;
  logic               nmi_s;

`ifdef IRQ_CTRL_INPUT_SYNC_EN
  // History only becomes meaningful once the synchronizers have filled.
  localparam logic [1:0] ARM_CYCLES = 2'd3;

  logic [NUM_SRC-1:0] src_meta;
  logic               nmi_meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_meta <= '0;
      src_s    <= '0;
      nmi_meta <= 1'b0;
      nmi_s    <= 1'b0;
    end else begin
      src_meta <= src_in;
      src_s    <= src_meta;
      nmi_meta <= nmi_src;
      nmi_s    <= nmi_meta;
    end
  end
`else
  localparam logic [1:0] ARM_CYCLES = 2'd1;

  assign src_s = src_in;
  assign nmi_s = nmi_src;
`endif

  logic [7:0] src_ext;
  logic [7:0] src_prev;
  logic       nmi_prev;
  logic [1:0] arm_cnt;
  logic       armed;
  logic [7:0] rise;
  logic       nmi_rise;

  always_comb begin
    src_ext                = '0;
    src_ext[NUM_SRC-1:0]   = src_s;
  end

  // History resets to 0, so the first cycles after reset only load it;
  // a line that is already high when reset drops must not look like an edge.
  assign armed    = (arm_cnt == ARM_CYCLES);
  assign rise     = armed ? (src_ext & ~src_prev) : 8'h00;
  assign nmi_rise = armed & nmi_s & ~nmi_prev;

  logic       wr_en;
  logic       rd_en;
  logic [7:0] w1c;
  logic [7:0] force_set;
  logic       sw_nmi;
  logic       nmi_set;

  assign wr_en     = cs & we;
  assign rd_en     = cs & ~we;
  assign w1c       = (wr_en && addr == 2'd0) ? (data_in & SRC_MASK) : 8'h00;
  assign force_set = (wr_en && addr == 2'd2) ? (data_in & SRC_MASK) : 8'h00;
  assign sw_nmi    = wr_en && (addr == 2'd3) && data_in[0];
  assign nmi_set   = nmi_rise | sw_nmi;

  logic [7:0] pending;
  logic [7:0] enable;
  logic [7:0] pending_nxt;
  logic [7:0] active;
  logic [7:0] vector;
  logic [7:0] rd_dat;

  // Clear is applied first so a simultaneous set always survives.
  assign pending_nxt = ((pending & ~w1c) | rise | force_set) & SRC_MASK;
  assign active      = pending & enable;

  always_comb begin
    vector = 8'h80;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vector = {5'd0, 3'(i)};
    end
  end

  always_comb begin
    case (addr)
      2'd0:    rd_dat = pending;
      2'd1:    rd_dat = enable;
      2'd2:    rd_dat = 8'h00;
      default: rd_dat = vector;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_prev <= '0;
      nmi_prev <= 1'b0;
      arm_cnt  <= '0;
      pending  <= '0;
      enable   <= '0;
      data_out <= '0;
      irq_n    <= 1'b1;
    end else begin
      src_prev <= src_ext;
      nmi_prev <= nmi_s;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
      pending <= pending_nxt;
      if (wr_en && addr == 2'd1) enable <= data_in & SRC_MASK;
      if (rd_en) data_out <= rd_dat;
      irq_n <= ~|active;
    end
  end

  logic [1:0]       nmi_state;
  logic [CNT_W-1:0] nmi_cnt;
  logic             nmi_req;

  // IDLE always lasts at least one cycle with nmi_n high, so it counts
  // toward the gap; GAP itself covers the remaining NMI_GAP_CYCLES-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_state <= ST_IDLE;
      nmi_cnt   <= '0;
      nmi_req   <= 1'b0;
      nmi_n     <= 1'b1;
    end else begin
      nmi_req <= nmi_req | nmi_set;
      case (nmi_state)
        ST_IDLE: begin
          if (nmi_req) begin
            nmi_req   <= nmi_set;
            nmi_n     <= 1'b0;
            nmi_cnt   <= CNT_W'(NMI_PULSE_CYCLES - 1);
            nmi_state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (nmi_cnt == '0) begin
            nmi_n <= 1'b1;
            if (NMI_GAP_CYCLES > 1) begin
              nmi_cnt   <= CNT_W'(NMI_GAP_CYCLES - 2);
              nmi_state <= ST_GAP;
            end else begin
              nmi_state <= ST_IDLE;
            end
          end else begin
            nmi_cnt <= nmi_cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (nmi_cnt == '0) nmi_state <= ST_IDLE;
          else               nmi_cnt   <= nmi_cnt - CNT_W'(1);
        end
        default: begin
          nmi_n     <= 1'b1;
          nmi_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with default parameters and no input synchronizers.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [7:0] src_in;
  logic       nmi_src;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       irq_n;
  logic       nmi_n;

  int checks = 0;
  int errors = 0;

  irq_controller dut (
    .clk      (clk),
    .reset    (reset),
    .src_in   (src_in),
    .nmi_src  (nmi_src),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .irq_n    (irq_n),
    .nmi_n    (nmi_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; data_in = 8'h00;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = data_out;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1; src_in = 8'hFF; nmi_src = 1'b0;
    cs = 1'b0; we = 1'b0; addr = 2'd0; data_in = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b want 1", irq_n); end
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL reset_nmi_n: got %b want 1", nmi_n); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL release_irq_n: got %b want 1", irq_n); end
    bus_rd(2'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL release_status: got %h want 00", v); end
    bus_rd(2'd1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL release_enable: got %h want 00", v); end
    bus_rd(2'd3, v);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL release_vector: got %h want 80", v); end
  endtask

  task automatic test_edge_latency;
    logic [7:0] v;
    bus_wr(2'd1, 8'h01);
    @(negedge clk); src_in[0] = 1'b0;
    @(negedge clk); src_in[0] = 1'b1;
    @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL edge_lat_1cyc: got %b want 1", irq_n); end
    @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL edge_lat_2cyc: got %b want 0", irq_n); end
    bus_rd(2'd0, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL edge_status: got %h want 01", v); end
  endtask

  task automatic test_w1c_collision;
    logic [7:0] v;
    @(negedge clk); src_in[0] = 1'b0;
    @(negedge clk); src_in[0] = 1'b1;
    cs = 1'b1; we = 1'b1; addr = 2'd0; data_in = 8'h01;
    @(negedge clk);
    cs = 1'b0; we = 1'b0; data_in = 8'h00;
    @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL w1c_coll_irq_a: got %b want 0", irq_n); end
    @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL w1c_coll_irq_b: got %b want 0", irq_n); end
    bus_rd(2'd0, v);
    checks++; if (v !== 8'h01) begin errors++; $display("FAIL w1c_coll_status: got %h want 01", v); end
    bus_wr(2'd0, 8'hFF);
    @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL w1c_clear_irq: got %b want 1", irq_n); end
  endtask

  task automatic test_vector;
    logic [7:0] v;
    bus_wr(2'd2, 8'h24);
    bus_wr(2'd1, 8'h20);
    @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL vec_irq_on: got %b want 0", irq_n); end
    bus_rd(2'd3, v);
    checks++; if (v !== 8'h05) begin errors++; $display("FAIL vec_bit5: got %h want 05", v); end
    bus_wr(2'd1, 8'h24);
    bus_rd(2'd3, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL vec_lowest: got %h want 02", v); end
    bus_wr(2'd1, 8'h20);
    bus_wr(2'd0, 8'h20);
    @(negedge clk);
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL vec_irq_off: got %b want 1", irq_n); end
    bus_rd(2'd3, v);
    checks++; if (v !== 8'h80) begin errors++; $display("FAIL vec_none: got %h want 80", v); end
    bus_rd(2'd0, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL vec_status_left: got %h want 04", v); end
    bus_wr(2'd0, 8'hFF);
    bus_wr(2'd1, 8'h00);
  endtask

  task automatic test_force;
    logic [7:0] v;
    bus_wr(2'd2, 8'h03);
    bus_rd(2'd0, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL force_status: got %h want 03", v); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL force_masked_irq: got %b want 1", irq_n); end
    bus_rd(2'd2, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL force_read: got %h want 00", v); end
    bus_wr(2'd1, 8'h02);
    @(negedge clk);
    checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL force_enabled_irq: got %b want 0", irq_n); end
    bus_wr(2'd0, 8'hFF);
    bus_wr(2'd1, 8'h00);
  endtask

  // pat[k] is nmi_src before edge k; exp[k] is nmi_n sampled after edge k.
  task automatic test_nmi_trace(input string name, input logic [19:0] pat, input logic [19:0] exp);
    @(negedge clk);
    nmi_src = pat[0];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (nmi_n !== exp[k]) begin
        errors++;
        $display("FAIL %s cycle %0d: nmi_n got %b want %b", name, k, nmi_n, exp[k]);
      end
      nmi_src = (k < 19) ? pat[k + 1] : 1'b0;
    end
    nmi_src = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    test_nmi_trace("nmi_two_edges", 20'b0000_0000_0000_0000_0101, 20'b1111_1111_1000_0110_0001);
  endtask

  task automatic test_nmi_collapse;
    test_nmi_trace("nmi_three_in_pulse", 20'b0000_0000_0000_0101_0101, 20'b1111_1111_1000_0110_0001);
  endtask

  task automatic test_nmi_reset;
    int low_seen;
    bus_wr(2'd3, 8'h01);
    @(negedge clk);
    checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL sw_nmi_low: got %b want 0", nmi_n); end
    @(posedge clk);
    #2;
    checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL sw_nmi_low2: got %b want 0", nmi_n); end
    reset = 1'b1;
    #1;
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL rst_mid_pulse: got %b want 1", nmi_n); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    low_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (nmi_n !== 1'b1) low_seen++;
    end
    checks++; if (low_seen != 0) begin errors++; $display("FAIL rst_no_pulse: got %0d low cycles want 0", low_seen); end
    checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL rst_irq_n: got %b want 1", irq_n); end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_w1c_collision();
    test_vector();
    test_force();
    test_back_to_back();
    test_nmi_collapse();
    test_nmi_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
